// File: rtl/inverse_linear_diffusion_layer.sv
// Iterative inverse of the Ascon linear diffusion layer (p_L^-1).
// Each lane map S(x) = x ^ ROTR(x,a) ^ ROTR(x,b) satisfies S^64 = id, so
// S^-1 = S^63 = product over k=0..5 of x ^ ROTR(x,a*2^k) ^ ROTR(x,b*2^k).
// The six squaring steps are applied UNROLL at a time, one group per cycle.
//
// Handshake: a state is accepted on a rising edge where in_valid_i and
// in_ready_o are both high; a result is consumed on a rising edge where
// out_valid_o and out_ready_i are both high. out_valid_o and state_array_o
// are held stable until consumed. in_valid_i is ignored outside IDLE.
module inverse_linear_diffusion_layer #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [319:0] state_array_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_array_o,
  output logic [1:0]   dbg_state_o
);

  // Only divisors of 6 make the step counter land exactly on 6.
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("inverse_linear_diffusion_layer: UNROLL must be 1, 2, 3 or 6");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] K_STEP = 3'(UNROLL);
  localparam logic [2:0] K_LAST = 3'(6 - UNROLL);

  // Per-lane rotate amounts, lane 0 = [319:256] ... lane 4 = [63:0].
  localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  state_t       r_state;
  state_t       w_state_nx;
  logic [319:0] r_acc;
  logic [2:0]   r_k;
  logic [319:0] w_chain;
  logic         w_load;
  logic         w_step;

  // Right rotation within a 64-bit lane.
  function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] amt);
    logic [127:0] w_dbl;
    w_dbl = {x, x} >> amt;
    return w_dbl[63:0];
  endfunction

  // One squaring step S_k applied to all five lanes; k outside 0..5 is a no-op.
  function automatic logic [319:0] sq_step(input logic [319:0] s, input logic [2:0] k);
    logic [319:0] w_res;
    logic [63:0]  w_x;
    logic [5:0]   w_sa;
    logic [5:0]   w_sb;
    w_res = s;
    if (k <= 3'd5) begin
      for (int i = 0; i < 5; i++) begin
        w_x  = s[319-64*i -: 64];
        w_sa = ROT_A[i] << k;
        w_sb = ROT_B[i] << k;
        w_res[319-64*i -: 64] = w_x ^ rotr64(w_x, w_sa) ^ rotr64(w_x, w_sb);
      end
    end
    return w_res;
  endfunction

  // Chain of UNROLL consecutive squaring steps starting at the current k.
  always_comb begin
    w_chain = r_acc;
    for (int u = 0; u < UNROLL; u++) begin
      w_chain = sq_step(w_chain, r_k + 3'(u));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_load     = 1'b1;
          w_state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_step = 1'b1;
        if (r_k == K_LAST) begin
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Accumulator and step counter; reset wipes any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_k   <= '0;
    end else if (w_load) begin
      r_acc <= state_array_i;
      r_k   <= '0;
    end else if (w_step) begin
      r_acc <= w_chain;
      r_k   <= r_k + K_STEP;
    end
  end

  assign state_array_o = r_acc;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_inverse_linear_diffusion_layer.sv
// Bench for inverse_linear_diffusion_layer: four instances (UNROLL 1,2,3,6)
// checked against a forward-layer model and expected values queued at drive time.
module tb_inverse_linear_diffusion_layer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [319:0] din       [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [319:0] dout      [4];
  logic [1:0]   dbg       [4];

  int unr [4] = '{1, 2, 3, 6};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    inverse_linear_diffusion_layer #(.UNROLL(U)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid_i    (in_valid[g]),
      .in_ready_o    (in_ready[g]),
      .state_array_i (din[g]),
      .out_valid_o   (out_valid[g]),
      .out_ready_i   (out_ready[g]),
      .state_array_o (dout[g]),
      .dbg_state_o   (dbg[g])
    );
  end

  // ---------------- scoreboard ----------------
  logic [319:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- forward-layer model ----------------
  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  function automatic logic [319:0] fwd(input logic [319:0] s);
    int a_tab [5];
    int b_tab [5];
    logic [319:0] r;
    logic [63:0] x;
    a_tab = '{19, 61, 1, 10, 7};
    b_tab = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) begin
      x = s[319-64*i -: 64];
      r[319-64*i -: 64] = x ^ rr(x, a_tab[i]) ^ rr(x, b_tab[i]);
    end
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver ----------------
  // One transaction on instance g; hold = cycles of backpressure in DONE,
  // during which a stray in_valid pulse is driven and must be ignored.
  task automatic run_txn(input int g, input logic [319:0] d, input logic [319:0] exp_v, input int hold);
    int edges;
    bit got;
    logic [319:0] e;
    @(negedge clk);
    check("in_ready_idle", in_ready[g], 1);
    in_valid[g] = 1'b1;
    din[g]      = d;
    @(posedge clk);
    exp_q.push_back(exp_v);
    #1;
    in_valid[g] = 1'b0;
    edges = 1;
    got   = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid[g]) got = 1;
    end
    check("out_valid_timeout", got, 1);
    if (!got) begin
      void'(exp_q.pop_front());
      return;
    end
    check("latency", edges, 6 / unr[g] + 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid[g] = (h == 1);
      din[g]      = ~d;
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid[g], 1);
      check("bp_data_stable", dout[g], exp_q[0]);
      check("bp_in_ready", in_ready[g], 0);
    end
    in_valid[g] = 1'b0;
    @(negedge clk);
    out_ready[g] = 1'b1;
    check("out_valid_hs", out_valid[g], 1);
    e = exp_q.pop_front();
    check("data", dout[g], e);
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
    check("idle_in_ready", in_ready[g], 1);
    check("idle_out_valid", out_valid[g], 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [319:0] s;
    logic [319:0] one_v;
    bit seen;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b0;
      din[g]       = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      check("rst_in_ready", in_ready[g], 1);
      check("rst_out_valid", out_valid[g], 0);
      check("rst_data", dout[g], '0);
      check("rst_state", dbg[g], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Fixed patterns on UNROLL=1
    run_txn(0, '0, '0, 0);
    run_txn(0, '1, '1, 0);
    one_v = 320'd1;
    run_txn(0, fwd(one_v), one_v, 0);
    s = '0;
    s[319] = 1'b1;
    run_txn(0, fwd(s), s, 0);
    s = {64'h0123456789abcdef, 64'h0, 64'hffffffffffffffff, 64'h8000000000000001, 64'hdeadbeefcafef00d};
    run_txn(0, fwd(s), s, 0);

    // Backpressure with a stray in_valid pulse
    s = rand_state();
    run_txn(0, fwd(s), s, 5);

    // Reset during BUSY aborts the operation
    s = rand_state();
    @(negedge clk);
    in_valid[0] = 1'b1;
    din[0]      = fwd(s);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", in_ready[0], 1);
    check("abort_out_valid", out_valid[0], 0);
    check("abort_data", dout[0], '0);
    check("abort_state", dbg[0], 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready[0] = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) seen = 1;
    end
    check("abort_no_output", seen, 0);
    out_ready[0] = 1'b0;

    // Round trip on every UNROLL variant
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 1000; n++) begin
        s = rand_state();
        run_txn(g, fwd(s), s, ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
